debouncer_bank: RTL and testbench
=================================

// Module: debouncer_bank
// PURPOSE
//  N-channel debouncer for the panel keys (start, stop, +time, door) feeding timer control.
//  Each channel: raw input -> synchroniser -> stability counter -> clean level + 1-cycle rise/fall pulses.
//  Optional auto-repeat produces press-and-hold pulses for the +time key.
// PARAMETERS
//  CHANNELS       4   number of independent input channels (>=1)
//  SYNC_STAGES    2   synchroniser flops per channel (>=2)
//  STABLE_CYCLES  4   consecutive differing samples needed to flip level (>=1)
//  REPEAT_DELAY   8   sample ticks from rise to first repeat (>=1; used with macro only)
//  REPEAT_PERIOD  4   sample ticks between later repeats (>=1; used with macro only)
// PORTS
//  clk          in   1         system clock, all logic on posedge
//  clear        in   1         synchronous active-high reset
//  sample_tick  in   1         counter enable strobe; tie 1 to count every clk
//  raw_in       in   CHANNELS  asynchronous bouncy inputs
//  level_out    out  CHANNELS  debounced level
//  rise_pulse   out  CHANNELS  1-clk pulse when level goes 0->1
//  fall_pulse   out  CHANNELS  1-clk pulse when level goes 1->0
//  rep_pulse    out  CHANNELS  1-clk auto-repeat pulse (constant 0 without macro)
// BEHAVIOUR
//  - Reset: clear=1 at posedge zeroes sync flops, counters, all outputs. Clear wins over everything.
//  - Sync chain shifts every clk, regardless of sample_tick; last stage = synced[i].
//  - Counter width = $clog2(STABLE_CYCLES+1); never wraps (reset before reaching STABLE_CYCLES).
//  - On posedge with sample_tick=1, per channel:
//      synced==level           -> cnt<=0
//      synced!=level, cnt<S-1  -> cnt<=cnt+1
//      synced!=level, cnt==S-1 -> level<=~level, cnt<=0, rise/fall pulse per new value
//  - sample_tick=0: cnt, level hold; no pulses.
//  - Pulses registered, asserted in the same cycle level_out changes, high exactly 1 clk.
//  - Latency (tick=1): raw held stable -> level changes SYNC_STAGES+STABLE_CYCLES edges after first edge that samples new value.
//  - Glitch shorter than STABLE_CYCLES samples at synced: no level change, no pulse; any matching sample restarts count.
//  - Channels fully independent; simultaneous changes on several channels each handled the same cycle.
//  - clear mid-count: count discarded; after release, full latency applies again.
// CONFIGURATION
//  Macro DEBOUNCE_BANK_REPEAT_EN:
//  - Defined: per-channel repeat counter ($clog2(max(DELAY,PERIOD)+1) bits).
//    rep_pulse asserts with rise_pulse, then on the tick REPEAT_DELAY ticks later,
//    then every REPEAT_PERIOD ticks while level stays 1. Counter counts ticks only.
//    Fall (or clear) cancels pending repeat; fall coinciding with a due repeat -> no rep_pulse.
//  - Undefined: no repeat logic synthesised; rep_pulse tied to 0.
// TESTING (CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=4, sample_tick=1 unless stated)
//  1 Clean press: raw_in[0] 0->1 held -> level_out[0]=1 and rise_pulse[0]=1 on 6th edge, pulse 1 clk only.
//  2 Bounce: raw_in[1] high 3 clk then low -> level_out[1] stays 0, no pulses; high 4 clk -> rises.
//  3 Release: after level_out[2]=1, raw_in[2]->0 -> fall_pulse[2] on 6th edge, level_out[2]=0.
//  4 Clear mid-count: raw_in[3]=1, clear at edge 4 for 1 clk -> all outputs 0; rise 6 edges after clear drops.
//  5 Tick gating: sample_tick 1-in-3 -> level change after 2 clk + 4 ticks; no change while tick=0.
//  6 Repeat (macro, DELAY=8, PERIOD=4): hold raw_in[0] -> rep_pulse at rise tick T, T+8, T+12, T+16; release stops; undefined -> rep_pulse always 0.

Source files
------------

// File: rtl/debouncer_bank_if.sv
//==============================================================================
// Module      : debouncer_bank_if
// Description : Tick strobe, raw key inputs and debounced outputs of the bank.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface debouncer_bank_if #(
  parameter int CHANNELS = 4
);
  logic                sample_tick;
  logic [CHANNELS-1:0] raw_in;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] rep_pulse;

  modport master (
    output sample_tick, raw_in,
    input  level_out, rise_pulse, fall_pulse, rep_pulse
  );

  modport slave (
    input  sample_tick, raw_in,
    output level_out, rise_pulse, fall_pulse, rep_pulse
  );
endinterface

`default_nettype wire

// File: rtl/debouncer_bank.sv
//==============================================================================
// Module      : debouncer_bank
// Description : N-channel key debouncer with edge pulses; press-and-hold
//               auto-repeat is built only when DEBOUNCE_BANK_REPEAT_EN is set.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debouncer_bank #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  wire logic         clk,
  input  wire logic         clear,
  debouncer_bank_if.slave   bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_flip;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CW-1:0]          r_cnt;
      logic                   r_lvl;
      logic                   r_rise;
      logic                   r_fall;
      logic                   w_synced;

      assign w_synced  = r_sync[SYNC_STAGES-1];
      assign w_flip[i] = bus.sample_tick && (w_synced != r_lvl) &&
                         (r_cnt == CW'(STABLE_CYCLES - 1));

      always_ff @(posedge clk) begin
        if (clear) begin
          r_sync <= '0;
          r_cnt  <= '0;
          r_lvl  <= 1'b0;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], bus.raw_in[i]};
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          if (bus.sample_tick) begin
            // Any sample agreeing with the current level restarts the run.
            if (w_synced == r_lvl) begin
              r_cnt <= '0;
            end else if (w_flip[i]) begin
              r_lvl  <= ~r_lvl;
              r_cnt  <= '0;
              r_rise <= ~r_lvl;
              r_fall <= r_lvl;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
      end

      assign w_level[i] = r_lvl;
      assign w_rise[i]  = r_rise;
      assign w_fall[i]  = r_fall;
    end
  endgenerate

  assign bus.level_out  = w_level;
  assign bus.rise_pulse = w_rise;
  assign bus.fall_pulse = w_fall;

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [CHANNELS-1:0] w_rep;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_rep
      logic [RW-1:0] r_rcnt;
      logic          r_rep;

      // Down-counter of ticks left until the next repeat; loaded on rise.
      always_ff @(posedge clk) begin
        if (clear) begin
          r_rcnt <= '0;
          r_rep  <= 1'b0;
        end else begin
          r_rep <= 1'b0;
          if (w_flip[i]) begin
            if (!w_level[i]) begin
              r_rep  <= 1'b1;
              r_rcnt <= RW'(REPEAT_DELAY);
            end else begin
              r_rcnt <= '0;
            end
          end else if (bus.sample_tick && w_level[i]) begin
            if (r_rcnt == RW'(1)) begin
              r_rep  <= 1'b1;
              r_rcnt <= RW'(REPEAT_PERIOD);
            end else begin
              r_rcnt <= r_rcnt - RW'(1);
            end
          end
        end
      end

      assign w_rep[i] = r_rep;
    end
  endgenerate

  assign bus.rep_pulse = w_rep;
`else
  // Repeat timing is only range-checked here so the tie-off stays constant 0.
  localparam logic c_rep_cfg_ok = (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);
  assign bus.rep_pulse = {CHANNELS{1'b0}} & {CHANNELS{c_rep_cfg_ok}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_debouncer_bank.sv
//==============================================================================
// Module      : tb_debouncer_bank
// Description : Directed and randomized bench for debouncer_bank against a
//               sliding-window reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_debouncer_bank;

  localparam int C_CH     = 4;
  localparam int C_SYNC   = 2;
  localparam int C_STABLE = 4;
  localparam int C_DELAY  = 8;
  localparam int C_PERIOD = 4;

  logic clk;
  logic clear;
  int   checks;
  int   errors;

  debouncer_bank_if #(.CHANNELS(C_CH)) bus ();

  debouncer_bank #(
    .CHANNELS      (C_CH),
    .SYNC_STAGES   (C_SYNC),
    .STABLE_CYCLES (C_STABLE),
    .REPEAT_DELAY  (C_DELAY),
    .REPEAT_PERIOD (C_PERIOD)
  ) u_dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: synced is raw delayed C_SYNC edges; a level flips when the
  // last C_STABLE ticked samples all disagree with it.
  logic [C_CH-1:0]     m_hist [$];
  logic [C_CH-1:0]     m_level;
  logic [C_STABLE-1:0] m_win [C_CH];
  int                  m_k [C_CH];
  logic [C_CH-1:0]     exp_level, exp_rise, exp_fall, exp_rep;

  always @(posedge clk) begin : p_model
    logic [C_CH-1:0] synced;
    logic            old_lvl;
    logic            flip;
    logic            hit;
    if (clear) begin
      m_hist.delete();
      for (int s = 0; s < C_SYNC; s++) m_hist.push_back('0);
      m_level   = '0;
      exp_level = '0;
      exp_rise  = '0;
      exp_fall  = '0;
      exp_rep   = '0;
      for (int c = 0; c < C_CH; c++) begin
        m_win[c] = '0;
        m_k[c]   = 0;
      end
    end else begin
      synced = m_hist.pop_front();
      m_hist.push_back(bus.raw_in);
      exp_rise = '0;
      exp_fall = '0;
      exp_rep  = '0;
      if (bus.sample_tick) begin
        for (int c = 0; c < C_CH; c++) begin
          m_win[c] = {m_win[c][C_STABLE-2:0], synced[c]};
          old_lvl  = m_level[c];
          flip     = (m_win[c] == {C_STABLE{~old_lvl}});
          hit      = 1'b0;
          if (flip) begin
            m_level[c]  = ~old_lvl;
            exp_rise[c] = ~old_lvl;
            exp_fall[c] = old_lvl;
          end
          if (flip && !old_lvl) begin
            m_k[c] = 0;
            hit    = 1'b1;
          end else if (old_lvl && !flip) begin
            m_k[c] = m_k[c] + 1;
            if (m_k[c] == C_DELAY ||
                (m_k[c] > C_DELAY && ((m_k[c] - C_DELAY) % C_PERIOD) == 0))
              hit = 1'b1;
          end
`ifdef DEBOUNCE_BANK_REPEAT_EN
          exp_rep[c] = hit;
`endif
        end
      end
      exp_level = m_level;
    end
  end

  task automatic do_clear();
    clear           = 1'b1;
    bus.raw_in      = '0;
    bus.sample_tick = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear           = 1'b1;
    bus.raw_in      = 4'hF;
    bus.sample_tick = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++; if (bus.level_out  !== 4'h0) begin errors++; $display("FAIL reset_level got %h exp 0", bus.level_out);  end
    checks++; if (bus.rise_pulse !== 4'h0) begin errors++; $display("FAIL reset_rise got %h exp 0",  bus.rise_pulse); end
    checks++; if (bus.fall_pulse !== 4'h0) begin errors++; $display("FAIL reset_fall got %h exp 0",  bus.fall_pulse); end
    checks++; if (bus.rep_pulse  !== 4'h0) begin errors++; $display("FAIL reset_rep got %h exp 0",   bus.rep_pulse);  end
    do_clear();
  endtask

  task automatic test_clean_press();
    do_clear();
    bus.raw_in[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.level_out[0] !== (e >= 6)) begin errors++; $display("FAIL press_level e%0d got %b exp %b", e, bus.level_out[0], e >= 6); end
      checks++; if (bus.rise_pulse[0] !== (e == 6)) begin errors++; $display("FAIL press_rise e%0d got %b exp %b", e, bus.rise_pulse[0], e == 6); end
    end
  endtask

  task automatic test_bounce();
    do_clear();
    bus.raw_in[1] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.level_out[1] !== 1'b0 || bus.rise_pulse[1] !== 1'b0 || bus.fall_pulse[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce3 e%0d got l%b r%b f%b exp 000", e, bus.level_out[1], bus.rise_pulse[1], bus.fall_pulse[1]);
      end
      if (e == 3) bus.raw_in[1] = 1'b0;
    end
    bus.raw_in[1] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.level_out[1] !== (e >= 6 && e < 10)) begin errors++; $display("FAIL bounce4_level e%0d got %b", e, bus.level_out[1]); end
      checks++; if (bus.rise_pulse[1] !== (e == 6)) begin errors++; $display("FAIL bounce4_rise e%0d got %b", e, bus.rise_pulse[1]); end
      checks++; if (bus.fall_pulse[1] !== (e == 10)) begin errors++; $display("FAIL bounce4_fall e%0d got %b", e, bus.fall_pulse[1]); end
      if (e == 4) bus.raw_in[1] = 1'b0;
    end
  endtask

  task automatic test_release();
    do_clear();
    bus.raw_in[2] = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    checks++; if (bus.level_out[2] !== 1'b1) begin errors++; $display("FAIL release_pre got %b exp 1", bus.level_out[2]); end
    bus.raw_in[2] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.level_out[2] !== (e < 6)) begin errors++; $display("FAIL release_level e%0d got %b exp %b", e, bus.level_out[2], e < 6); end
      checks++; if (bus.fall_pulse[2] !== (e == 6)) begin errors++; $display("FAIL release_fall e%0d got %b exp %b", e, bus.fall_pulse[2], e == 6); end
    end
  endtask

  task automatic test_clear_mid();
    do_clear();
    bus.raw_in[3] = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      clear = (e == 4);
      @(posedge clk);
      #1;
      if (e == 4) begin
        checks++;
        if (bus.level_out !== 4'h0 || bus.rise_pulse !== 4'h0 || bus.fall_pulse !== 4'h0 || bus.rep_pulse !== 4'h0) begin
          errors++;
          $display("FAIL clearmid_zero got l%h r%h f%h p%h exp 0", bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.rep_pulse);
        end
      end else begin
        checks++; if (bus.level_out[3] !== (e >= 10)) begin errors++; $display("FAIL clearmid_level e%0d got %b exp %b", e, bus.level_out[3], e >= 10); end
        checks++; if (bus.rise_pulse[3] !== (e == 10)) begin errors++; $display("FAIL clearmid_rise e%0d got %b exp %b", e, bus.rise_pulse[3], e == 10); end
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_tick_gating();
    do_clear();
    bus.raw_in[0] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      bus.sample_tick = ((e % 3) == 0);
      @(posedge clk);
      #1;
      checks++; if (bus.level_out[0] !== (e >= 12)) begin errors++; $display("FAIL tick_level e%0d got %b exp %b", e, bus.level_out[0], e >= 12); end
      checks++; if (bus.rise_pulse[0] !== (e == 12)) begin errors++; $display("FAIL tick_rise e%0d got %b exp %b", e, bus.rise_pulse[0], e == 12); end
    end
    bus.sample_tick = 1'b1;
  endtask

  task automatic test_simultaneous();
    do_clear();
    bus.raw_in = 4'hF;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.level_out !== ((e >= 6) ? 4'hF : 4'h0)) begin errors++; $display("FAIL simul_level e%0d got %h", e, bus.level_out); end
      checks++; if (bus.rise_pulse !== ((e == 6) ? 4'hF : 4'h0)) begin errors++; $display("FAIL simul_rise e%0d got %h", e, bus.rise_pulse); end
    end
    bus.raw_in = 4'h0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.fall_pulse !== ((e == 6) ? 4'hF : 4'h0)) begin errors++; $display("FAIL simul_fall e%0d got %h", e, bus.fall_pulse); end
    end
  endtask

  task automatic test_repeat();
    logic want;
    do_clear();
    bus.raw_in[0] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
`ifdef DEBOUNCE_BANK_REPEAT_EN
      want = (e == 6 || e == 14 || e == 18 || e == 22 || e == 26);
`else
      want = 1'b0;
`endif
      checks++; if (bus.rep_pulse[0] !== want) begin errors++; $display("FAIL repeat e%0d got %b exp %b", e, bus.rep_pulse[0], want); end
      checks++; if (bus.fall_pulse[0] !== (e == 30)) begin errors++; $display("FAIL repeat_fall e%0d got %b exp %b", e, bus.fall_pulse[0], e == 30); end
      if (e == 24) bus.raw_in[0] = 1'b0;
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < C_CH; c++)
        if ($urandom_range(0, 5) == 0) bus.raw_in[c] = ~bus.raw_in[c];
      bus.sample_tick = ($urandom_range(0, 3) != 0);
      clear           = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
      checks++; if (bus.level_out  !== exp_level) begin errors++; $display("FAIL rand_level n%0d got %h exp %h", n, bus.level_out,  exp_level); end
      checks++; if (bus.rise_pulse !== exp_rise)  begin errors++; $display("FAIL rand_rise n%0d got %h exp %h",  n, bus.rise_pulse, exp_rise);  end
      checks++; if (bus.fall_pulse !== exp_fall)  begin errors++; $display("FAIL rand_fall n%0d got %h exp %h",  n, bus.fall_pulse, exp_fall);  end
      checks++; if (bus.rep_pulse  !== exp_rep)   begin errors++; $display("FAIL rand_rep n%0d got %h exp %h",   n, bus.rep_pulse,  exp_rep);   end
    end
    clear           = 1'b0;
    bus.sample_tick = 1'b1;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    clear           = 1'b1;
    bus.raw_in      = '0;
    bus.sample_tick = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_clear_mid();
    test_tick_gating();
    test_simultaneous();
    test_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
